ram_dp_param: RTL

Parametrised single-clock true dual-port RAM, the generalised successor to the fixed 8K x 8 dual-port buffer used by the control-station data paths. Two independent read/write ports share one array. Each port has an explicit read enable, a read-valid flag, and a selectable output pipeline stage. The block defines same-cycle collision and read-during-write behaviour, and optional per-word parity checking. It sits between the protocol engines and the shared station data image.

---
 rtl/ram_dp_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: single-clock true dual-port RAM with read-valid, optional output register
// and optional per-word parity, enabled by defining the macro RAM_DP_PARITY_EN.
module ram_dp_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 13,
   parameter int DEPTH    = 8192,
   parameter int OUT_REG  = 1,
   parameter int RDW_MODE = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_DIN,
   input  logic              A_WEN,
   input  logic              A_REN,
   output logic [DATA_W-1:0] A_DOUT,
   output logic              A_VALID,
   output logic              A_PERR,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_DIN,
   input  logic              B_WEN,
   input  logic              B_REN,
   output logic [DATA_W-1:0] B_DOUT,
   output logic              B_VALID,
   output logic              B_PERR,
   output logic              COLL,
   input  logic              PAR_INJ
);

`ifdef RAM_DP_PARITY_EN
   localparam int MEM_W  = DATA_W + 1;
   localparam bit PAR_EN = 1'b1;

   function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] din);
      return {(^din) ^ PAR_INJ, din};
   endfunction
`else
   localparam int MEM_W  = DATA_W;
   localparam bit PAR_EN = 1'b0;

   logic unused_par_inj;
   assign unused_par_inj = PAR_INJ;

   function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] din);
      return din;
   endfunction
`endif

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [MEM_W-1:0] mem [DEPTH];

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return 64'(addr) < 64'(DEPTH);
   endfunction

   // A stored word (data plus even-parity bit) must XOR to zero.
   function automatic logic perr_of(input logic [MEM_W-1:0] word);
      return PAR_EN && (^word);
   endfunction

   logic a_wr, b_wr, ab_same;
   assign ab_same = (A_ADDR == B_ADDR);
   assign a_wr    = A_WEN && in_range(A_ADDR);
   assign b_wr    = B_WEN && in_range(B_ADDR) && !(a_wr && ab_same);

   always_ff @(posedge CLK) begin
      if (a_wr) mem[A_ADDR[IDX_W-1:0]] <= enc(A_DIN);
      if (b_wr) mem[B_ADDR[IDX_W-1:0]] <= enc(B_DIN);
   end

   // Array reads see pre-edge contents, so cross-port readers always get old data.
   logic [MEM_W-1:0] a_word, b_word;
   always_comb begin
      a_word = '0;
      if (in_range(A_ADDR))
         a_word = (RDW_MODE == 1 && a_wr) ? enc(A_DIN) : mem[A_ADDR[IDX_W-1:0]];
   end

   always_comb begin
      b_word = '0;
      if (in_range(B_ADDR))
         b_word = (RDW_MODE == 1 && b_wr) ? enc(B_DIN) : mem[B_ADDR[IDX_W-1:0]];
   end

   // Stage p0: array output capture
   logic              vld_a_p0, vld_b_p0, perr_a_p0, perr_b_p0;
   logic [DATA_W-1:0] dat_a_p0, dat_b_p0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_a_p0  <= 1'b0;
         vld_b_p0  <= 1'b0;
         perr_a_p0 <= 1'b0;
         perr_b_p0 <= 1'b0;
         dat_a_p0  <= '0;
         dat_b_p0  <= '0;
         COLL      <= 1'b0;
      end else begin
         vld_a_p0 <= A_REN;
         vld_b_p0 <= B_REN;
         COLL     <= A_WEN && B_WEN && ab_same && in_range(A_ADDR);
         if (A_REN) begin
            dat_a_p0  <= a_word[DATA_W-1:0];
            perr_a_p0 <= perr_of(a_word);
         end
         if (B_REN) begin
            dat_b_p0  <= b_word[DATA_W-1:0];
            perr_b_p0 <= perr_of(b_word);
         end
      end
   end

   // Stage p1: optional output register
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic              vld_a_p1, vld_b_p1, perr_a_p1, perr_b_p1;
         logic [DATA_W-1:0] dat_a_p1, dat_b_p1;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               vld_a_p1  <= 1'b0;
               vld_b_p1  <= 1'b0;
               perr_a_p1 <= 1'b0;
               perr_b_p1 <= 1'b0;
               dat_a_p1  <= '0;
               dat_b_p1  <= '0;
            end else begin
               vld_a_p1 <= vld_a_p0;
               vld_b_p1 <= vld_b_p0;
               if (vld_a_p0) begin
                  dat_a_p1  <= dat_a_p0;
                  perr_a_p1 <= perr_a_p0;
               end
               if (vld_b_p0) begin
                  dat_b_p1  <= dat_b_p0;
                  perr_b_p1 <= perr_b_p0;
               end
            end
         end

         assign A_DOUT  = dat_a_p1;
         assign A_VALID = vld_a_p1;
         assign A_PERR  = perr_a_p1 && vld_a_p1;
         assign B_DOUT  = dat_b_p1;
         assign B_VALID = vld_b_p1;
         assign B_PERR  = perr_b_p1 && vld_b_p1;
      end else begin : g_direct
         assign A_DOUT  = dat_a_p0;
         assign A_VALID = vld_a_p0;
         assign A_PERR  = perr_a_p0 && vld_a_p0;
         assign B_DOUT  = dat_b_p0;
         assign B_VALID = vld_b_p0;
         assign B_PERR  = perr_b_p0 && vld_b_p0;
      end
   endgenerate

endmodule
